m_dmem_arbiter: RTL
===================

# m_dmem_arbiter

Arbiter that shares the single-port synchronous data memory between the pipeline MEM stage (port P) and an external loader/debug master (port X). P has priority; X uses a valid/ready handshake and is protected from starvation by a bounded-wait counter. When X wins while P is requesting, the block stalls the pipeline. Read data returns to the requester that issued the read, tagged by a per-port valid pulse.

## Interface
- ADDR_W, 12, word address width (matches the 4K-word memory)
- DATA_W, 32, data width
- STARVE_MAX, 8, maximum consecutive cycles X may be denied; legal range 1..255
- w_clk  in  1  clock
- w_rst_n  in  1  reset, asynchronous, active-low
- w_ce  in  1  clock enable; all registers update only when high
- w_p_req  in  1  MEM stage access request (load or store)
- w_p_we  in  1  P store
- w_p_addr  in  ADDR_W  P word address
- w_p_wdata  in  DATA_W  P store data
- w_p_stall  out  1  P request not granted this cycle; pipeline must hold
- w_p_rvalid  out  1  P read data valid
- w_p_rdata  out  DATA_W  P read data
- w_x_valid  in  1  X request valid
- w_x_ready  out  1  X request accepted this cycle
- w_x_we  in  1  X write
- w_x_addr  in  ADDR_W  X word address
- w_x_wdata  in  DATA_W  X write data
- w_x_rvalid  out  1  X read data valid
- w_x_rdata  out  DATA_W  X read data
- w_m_addr  out  ADDR_W  memory address
- w_m_we  out  1  memory write enable
- w_m_din  out  DATA_W  memory write data
- w_m_dout  in  DATA_W  memory read data, valid one cycle after address

## Operation
- Grant is computed combinationally each cycle: GNT_X if (w_x_valid & (!w_p_req | force_x)); GNT_P if w_p_req and not GNT_X; otherwise GNT_NONE.
- force_x = (starve_cnt == STARVE_MAX).
- starve_cnt: increments (saturating at STARVE_MAX) on each cycle with w_x_valid & !GNT_X; clears on GNT_X or when w_x_valid is low.
- Memory mux: w_m_addr, w_m_we, and w_m_din follow the granted port. On GNT_NONE: address = last granted address, w_m_we = 0.
- w_x_ready = GNT_X & w_ce. The transfer occurs on a posedge with valid & ready. X must hold its payload stable while valid & !ready.
- w_p_stall = w_p_req & !GNT_P.
- Response tag register resp ∈ {NONE, P, X}, loaded with the grant of each read (we = 0); writes load NONE.
- w_p_rvalid = (resp == P); w_x_rvalid = (resp == X).
- Both rdata outputs are driven from w_m_dout. The data is meaningful only while the matching rvalid is high.
- w_ce low:
  - no grant
  - w_m_we = 0, w_x_ready = 0, w_p_stall = 0
  - starve_cnt and resp held
- Reset (async, any time): starve_cnt = 0, resp = NONE. Any in-flight read response is dropped.

## Timing
- Reset values: w_p_stall 0, w_x_ready 0, w_p_rvalid 0, w_x_rvalid 0, w_m_we 0, w_m_addr 0, w_m_din 0, rdata follows w_m_dout.
- Read latency is 1 cycle: grant in cycle N; rvalid and data in cycle N+1.
- Write commits at the posedge ending the grant cycle.
- Back-to-back grants to either port are allowed every cycle. X sustains 1 transfer per cycle while P is idle.
- Worst-case X wait under continuous P traffic: STARVE_MAX denied cycles, then grant; P is stalled exactly 1 cycle.
- Simultaneous P and X with force_x low: P wins and the counter increments.
- Address collision (X write in cycle N, P read of the same address in N+1): P sees the new data.

## Configuration
- DMEM_ARB_STARVE_EN:
  - Defined: the starvation counter and force_x are present as described.
  - Undefined: strict P priority, force_x is constant 0, no counter registers. X is granted only on cycles with w_p_req low, and w_p_stall is then constant 0.

## Structure
- Shared package dmem_pkg holds:
  - grant/resp encoding: GNT_NONE = 2'd0, GNT_P = 2'd1, GNT_X = 2'd2
  - default ADDR_W/DATA_W constants, also used by m_data_memory users
- One sub-module: m_starve_counter (saturating counter with clear, width from $clog2(STARVE_MAX+1)), instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset mid-read: assert w_rst_n = 0 one cycle after an X read grant -> w_x_rvalid stays 0, counter 0.
- P-only traffic: P read addr 5 (mem[5] = 32'hDEADBEEF) -> w_p_stall 0, w_p_rvalid 1 next cycle, w_p_rdata 32'hDEADBEEF.
- X write then read while P idle: write 32'h12345678 to addr 9, then read addr 9 -> w_x_ready high both cycles, w_x_rvalid 1 cycle after the read, data 32'h12345678.
- Starvation with macro, STARVE_MAX = 8: w_p_req held high, X valid held -> X granted on the 9th cycle, w_p_stall high that cycle only, counter back to 0.
- Same stimulus without macro -> X never granted, w_p_stall never asserted. Drop w_p_req -> X granted the same cycle.
- w_ce low for 3 cycles during contention -> no memory write, ready/stall 0, counter value unchanged after w_ce returns high.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: default geometry and the grant/response tag encoding
// used by the arbiter and by m_data_memory users.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  // Grant and response tag share one encoding so a read grant can be stored as its tag.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_X    = 2'd2
  } gnt_t;

endpackage

// File: rtl/m_starve_counter.sv
// Saturating up-counter with synchronous clear and clock enable; counts denied cycles of
// the external master so the arbiter can force a grant at MAX.
module m_starve_counter #(
  parameter  int MAX = 8,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ce) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != W'(MAX))) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/m_dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (P, priority) and an external
// loader/debug master (X, valid/ready). Build with DMEM_ARB_STARVE_EN to bound X's wait.
module m_dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_ce,
  input  logic              w_p_req,
  input  logic              w_p_we,
  input  logic [ADDR_W-1:0] w_p_addr,
  input  logic [DATA_W-1:0] w_p_wdata,
  output logic              w_p_stall,
  output logic              w_p_rvalid,
  output logic [DATA_W-1:0] w_p_rdata,
  input  logic              w_x_valid,
  output logic              w_x_ready,
  input  logic              w_x_we,
  input  logic [ADDR_W-1:0] w_x_addr,
  input  logic [DATA_W-1:0] w_x_wdata,
  output logic              w_x_rvalid,
  output logic [DATA_W-1:0] w_x_rdata,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [DATA_W-1:0] w_m_din,
  input  logic [DATA_W-1:0] w_m_dout
);

  // X handshake: a request transfers on a posedge where w_x_valid & w_x_ready are both
  // high; while valid is high and ready low, X holds we/addr/wdata stable.

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("m_dmem_arbiter: STARVE_MAX must be within 1..255");
  end

  gnt_t              gnt;
  gnt_t              resp;
  logic              force_x;
  logic [ADDR_W-1:0] last_addr;

  always_comb begin
    gnt = GNT_NONE;
    if (w_ce) begin
      if (w_x_valid && (!w_p_req || force_x)) begin
        gnt = GNT_X;
      end else if (w_p_req) begin
        gnt = GNT_P;
      end
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  m_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .ce    (w_ce),
    .inc   (w_x_valid && (gnt != GNT_X)),
    .clr   (!w_x_valid || (gnt == GNT_X)),
    .cnt   (starve_cnt)
  );

  assign force_x   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign w_p_stall = w_p_req && w_ce && (gnt != GNT_P);
`else
  // Strict priority: P always wins when it asks, so it can never be stalled.
  assign force_x   = 1'b0;
  assign w_p_stall = 1'b0;
`endif

  // An idle cycle keeps the last address on the bus to avoid needless address toggling.
  always_comb begin
    w_m_addr = last_addr;
    w_m_we   = 1'b0;
    w_m_din  = '0;
    case (gnt)
      GNT_P: begin
        w_m_addr = w_p_addr;
        w_m_we   = w_p_we;
        w_m_din  = w_p_wdata;
      end
      GNT_X: begin
        w_m_addr = w_x_addr;
        w_m_we   = w_x_we;
        w_m_din  = w_x_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      resp      <= GNT_NONE;
      last_addr <= '0;
    end else if (w_ce) begin
      resp <= w_m_we ? GNT_NONE : gnt;
      if (gnt != GNT_NONE) begin
        last_addr <= w_m_addr;
      end
    end
  end

  assign w_x_ready  = (gnt == GNT_X);
  assign w_p_rvalid = (resp == GNT_P);
  assign w_x_rvalid = (resp == GNT_X);
  assign w_p_rdata  = w_m_dout;
  assign w_x_rdata  = w_m_dout;

endmodule
